// File: rtl/divider_datapath_pkg.sv
// Shared definitions for the sequential non-restoring divider datapath.
package divider_datapath_pkg;

    typedef enum logic {
        OP_SUB = 1'b0,
        OP_ADD = 1'b1
    } addsub_op_e;

endpackage

// File: rtl/divider_datapath_addsub.sv
// Combinational W-bit adder/subtractor; the carry-out is dropped by the W-bit result.
module addsub_n
    import divider_datapath_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic [W-1:0] y
);

    // Select sum or difference from the op mode.
    always_comb begin
        y = a;
        if (op == OP_ADD) begin
            y = a + b;
        end else begin
            y = a - b;
        end
    end

endmodule

// File: rtl/divider_datapath.sv
// Register datapath (A, Q, M, count) for the N-bit non-restoring unsigned divider,
// executing the load/shift/add-sub/set-Q0 micro-operations strobed by the control FSM.
module divider_datapath
    import divider_datapath_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             dividend,
    input  logic [N-1:0]             divisor,
    input  logic                     load,
    input  logic                     hab_A,
    input  logic                     shift,
    input  logic                     set_Q0,
    input  logic                     op,
    output logic [N:0]               A,
    output logic [$clog2(N+1)-1:0]   count,
    output logic [N-1:0]             quotient,
    output logic [N-1:0]             remainder,
    output logic                     div_zero
);

    localparam int CW = $clog2(N+1);

    logic [N:0]    a_r;
    logic [N-1:0]  q_r;
    logic [N-1:0]  m_r;
    logic [CW-1:0] count_r;
    logic          div_zero_r;

    logic [N:0]    sum_s;
    logic [N:0]    a_next_s;
    logic [N-1:0]  q_next_s;
    logic [N-1:0]  m_next_s;
    logic [CW-1:0] count_next_s;
    logic          div_zero_next_s;

    addsub_n #(.W(N+1)) u_addsub (
        .a  (a_r),
        .b  ({1'b0, m_r}),
        .op (op),
        .y  (sum_s)
    );

    // Next-state selection; shift beats hab_A, and set_Q0 lands after any shift.
    always_comb begin
        a_next_s        = a_r;
        q_next_s        = q_r;
        m_next_s        = m_r;
        count_next_s    = count_r;
        div_zero_next_s = div_zero_r;
        if (load) begin
            a_next_s        = '0;
            q_next_s        = dividend;
            m_next_s        = divisor;
            count_next_s    = '0;
            div_zero_next_s = (divisor == '0);
        end else begin
            if (shift) begin
                {a_next_s, q_next_s} = {a_r[N-1:0], q_r, 1'b0};
                count_next_s         = count_r + CW'(1);
            end else if (hab_A) begin
                a_next_s = sum_s;
            end else begin
                a_next_s = a_r;
            end
            if (set_Q0) begin
                q_next_s[0] = 1'b1;
            end else begin
                q_next_s[0] = q_next_s[0];
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            q_r        <= '0;
            m_r        <= '0;
            count_r    <= '0;
            div_zero_r <= 1'b0;
        end else begin
            a_r        <= a_next_s;
            q_r        <= q_next_s;
            m_r        <= m_next_s;
            count_r    <= count_next_s;
            div_zero_r <= div_zero_next_s;
        end
    end

    assign A         = a_r;
    assign count     = count_r;
    assign quotient  = q_r;
    assign remainder = a_r[N-1:0];
    assign div_zero  = div_zero_r;

endmodule
